// File: rtl/mult_pkg.sv
// Shared mode encodings, status bit positions and mode decode helpers
// for the pipelined EX-stage multiplier.
package mult_pkg;

  localparam logic [1:0] MODE_ULO = 2'b00;
  localparam logic [1:0] MODE_SLO = 2'b01;
  localparam logic [1:0] MODE_UHI = 2'b10;
  localparam logic [1:0] MODE_SHI = 2'b11;

  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_OVF_BIT   = 1;

  function automatic logic modeIsSigned(input logic [1:0] m);
    return m[0];
  endfunction

  function automatic logic modeIsHigh(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/mult_pipe_reg.sv
// One retiming stage of the multiplier pipe: a valid bit plus an opaque payload,
// held while en_i is low and with valid cleared synchronously by clr_i.
module mult_pipe_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;

  // Clear wins over enable so a flush also kills ops during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (clr_i) begin
      valid_q   <= 1'b0;
    end else if (en_i) begin
      valid_q   <= valid_i;
      payload_q <= payload_i;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined integer multiplier with signed/unsigned and low/high-half modes,
// overflow flag, stall and flush; the instruction word rides along with each op.
module multiplier_pipe
  import mult_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int STAGES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [1:0]         mode,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  product,
  output logic [1:0]         mult_status,
  output logic [INSTR_W-1:0] ex_instr_out,
  output logic               busy
);

  localparam int FULL_W    = 2 * DATA_W;
  localparam int PAYLOAD_W = INSTR_W + 2 + FULL_W;
  localparam int NREG      = STAGES - 1;

  logic [FULL_W-1:0] aExt;
  logic [FULL_W-1:0] bExt;
  logic [FULL_W-1:0] fullIn;

  // A 2W x 2W product truncated to 2W bits is exact for both signednesses.
  always_comb begin
    aExt = {{DATA_W{1'b0}}, A};
    bExt = {{DATA_W{1'b0}}, B};
    if (modeIsSigned(mode)) begin
      aExt = {{DATA_W{A[DATA_W-1]}}, A};
      bExt = {{DATA_W{B[DATA_W-1]}}, B};
    end
    fullIn = aExt * bExt;
  end

  logic                 stValid   [NREG+1];
  logic [PAYLOAD_W-1:0] stPayload [NREG+1];

  assign stValid[0]   = in_valid;
  assign stPayload[0] = {instr, mode, fullIn};

  generate
    for (genvar i = 0; i < NREG; i++) begin : genStage
      mult_pipe_reg #(
        .PAYLOAD_W(PAYLOAD_W)
      ) uStage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (~stall),
        .clr_i    (flush),
        .valid_i  (stValid[i]),
        .payload_i(stPayload[i]),
        .valid_o  (stValid[i+1]),
        .payload_o(stPayload[i+1])
      );
    end
  endgenerate

  logic               lastValid;
  logic [INSTR_W-1:0] lastInstr;
  logic [1:0]         lastMode;
  logic [FULL_W-1:0]  lastFull;

  assign lastValid                        = stValid[NREG];
  assign {lastInstr, lastMode, lastFull}  = stPayload[NREG];

  logic               validD;
  logic               ovfD;
  logic [DATA_W-1:0]  productD;
  logic [INSTR_W-1:0] instrD;

  // Invalid ops leave everything at zero so the output reads as a NOP bubble.
  always_comb begin
    validD   = 1'b0;
    ovfD     = 1'b0;
    productD = '0;
    instrD   = '0;
    if (lastValid) begin
      validD   = 1'b1;
      instrD   = lastInstr;
      productD = modeIsHigh(lastMode) ? lastFull[FULL_W-1:DATA_W] : lastFull[DATA_W-1:0];
      case (lastMode)
        MODE_ULO: ovfD = |lastFull[FULL_W-1:DATA_W];
        MODE_SLO: ovfD = (lastFull != {{DATA_W{lastFull[DATA_W-1]}}, lastFull[DATA_W-1:0]});
        default:  ovfD = 1'b0;
      endcase
    end
  end

  logic               outValid_q;
  logic               ovf_q;
  logic [DATA_W-1:0]  product_q;
  logic [INSTR_W-1:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      ovf_q      <= 1'b0;
      product_q  <= '0;
      instr_q    <= '0;
    end else if (flush) begin
      outValid_q <= 1'b0;
      ovf_q      <= 1'b0;
      product_q  <= '0;
      instr_q    <= '0;
    end else if (!stall) begin
      outValid_q <= validD;
      ovf_q      <= ovfD;
      product_q  <= productD;
      instr_q    <= instrD;
    end
  end

  logic busyD;

  always_comb begin
    busyD = outValid_q;
    for (int i = 1; i <= NREG; i++) begin
      busyD = busyD | stValid[i];
    end
  end

  assign product                        = product_q;
  assign mult_status[STATUS_VALID_BIT]  = outValid_q;
  assign mult_status[STATUS_OVF_BIT]    = ovf_q;
  assign ex_instr_out                   = instr_q;
  assign busy                           = busyD;

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed self-checking bench for multiplier_pipe: 16-bit/3-stage main instance
// plus 8-bit/1-stage and 32-bit/5-stage instances for the parametric cases.
module tb_multiplier_pipe;

  localparam int S16 = 3;
  localparam int S8  = 1;
  localparam int S32 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        inValid, stall, flush;
  logic [15:0] instr, a, b;
  logic [1:0]  mode;
  logic [15:0] product;
  logic [1:0]  status;
  logic [15:0] exInstr;
  logic        busy;

  logic        inValid8;
  logic [15:0] instr8;
  logic [7:0]  a8, b8;
  logic [1:0]  mode8;
  logic [7:0]  product8;
  logic [1:0]  status8;
  logic [15:0] exInstr8;
  logic        busy8;

  logic        inValid32;
  logic [15:0] instr32;
  logic [31:0] a32, b32;
  logic [1:0]  mode32;
  logic [31:0] product32;
  logic [1:0]  status32;
  logic [15:0] exInstr32;
  logic        busy32;

  int checkCount = 0;
  int passCount  = 0;

  multiplier_pipe #(.DATA_W(16), .INSTR_W(16), .STAGES(S16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .instr(instr), .A(a), .B(b),
    .mode(mode), .stall(stall), .flush(flush), .product(product),
    .mult_status(status), .ex_instr_out(exInstr), .busy(busy)
  );

  multiplier_pipe #(.DATA_W(8), .INSTR_W(16), .STAGES(S8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .instr(instr8), .A(a8), .B(b8),
    .mode(mode8), .stall(1'b0), .flush(1'b0), .product(product8),
    .mult_status(status8), .ex_instr_out(exInstr8), .busy(busy8)
  );

  multiplier_pipe #(.DATA_W(32), .INSTR_W(16), .STAGES(S32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid32), .instr(instr32), .A(a32), .B(b32),
    .mode(mode32), .stall(1'b0), .flush(1'b0), .product(product32),
    .mult_status(status32), .ex_instr_out(exInstr32), .busy(busy32)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    inValid = 0; stall = 0; flush = 0; instr = '0; a = '0; b = '0; mode = '0;
    inValid8 = 0; instr8 = '0; a8 = '0; b8 = '0; mode8 = '0;
    inValid32 = 0; instr32 = '0; a32 = '0; b32 = '0; mode32 = '0;
    tick();
    checkCount++;
    if ({product, status, exInstr, busy} !== 35'd0)
      $display("[TB] FAIL reset16: got %h expected 0", {product, status, exInstr, busy});
    else passCount++;
    checkCount++;
    if ({product8, status8, exInstr8, busy8} !== 27'd0 || {product32, status32, exInstr32, busy32} !== 51'd0)
      $display("[TB] FAIL reset_param: got %h / %h expected 0",
               {product8, status8, exInstr8, busy8}, {product32, status32, exInstr32, busy32});
    else passCount++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_low;
    inValid = 1; a = 16'd2; b = 16'd8; mode = 2'b00; instr = 16'h5123;
    tick();
    inValid = 0; a = 16'hDEAD; b = 16'hBEEF; instr = 16'hFFFF;
    tick();
    checkCount++;
    if (status !== 2'b00)
      $display("[TB] FAIL ulo_latency: status=%b expected 00", status);
    else passCount++;
    tick();
    checkCount++;
    if ({product, status, exInstr} !== {16'h0010, 2'b01, 16'h5123})
      $display("[TB] FAIL ulo_result: got %h expected %h", {product, status, exInstr}, {16'h0010, 2'b01, 16'h5123});
    else passCount++;
    tick();
    checkCount++;
    if ({product, status, exInstr, busy} !== 35'd0)
      $display("[TB] FAIL ulo_bubble: got %h expected 0", {product, status, exInstr, busy});
    else passCount++;
  endtask

  task automatic test_overflow_high;
    logic [1:0]  opM [2];
    logic [15:0] expP [2];
    logic [1:0]  expS [2];
    int k;
    opM  = '{2'b00, 2'b10};
    expP = '{16'h7958, 16'h0001};
    expS = '{2'b11, 2'b01};
    for (int c = 0; c < 2 + S16 - 1; c++) begin
      if (c < 2) begin
        inValid = 1; a = 16'd300; b = 16'd322; mode = opM[c]; instr = 16'(16'h5200 + c);
      end else inValid = 0;
      tick();
      if (c >= S16 - 1) begin
        k = c - (S16 - 1);
        checkCount++;
        if ({product, status, exInstr} !== {expP[k], expS[k], 16'(16'h5200 + k)})
          $display("[TB] FAIL ovf_high[%0d]: got %h expected %h", k, {product, status, exInstr},
                   {expP[k], expS[k], 16'(16'h5200 + k)});
        else passCount++;
      end
    end
  endtask

  task automatic test_signed;
    logic [1:0]  opM [3];
    logic [15:0] expP [3];
    logic [1:0]  expS [3];
    int k;
    opM  = '{2'b01, 2'b11, 2'b00};
    expP = '{16'hFFF1, 16'hFFFF, 16'hFFF1};
    expS = '{2'b01, 2'b01, 2'b11};
    for (int c = 0; c < 3 + S16 - 1; c++) begin
      if (c < 3) begin
        inValid = 1; a = 16'hFFFD; b = 16'd5; mode = opM[c]; instr = 16'(16'h5300 + c);
      end else inValid = 0;
      tick();
      if (c >= S16 - 1) begin
        k = c - (S16 - 1);
        checkCount++;
        if ({product, status, exInstr} !== {expP[k], expS[k], 16'(16'h5300 + k)})
          $display("[TB] FAIL signed[%0d]: got %h expected %h", k, {product, status, exInstr},
                   {expP[k], expS[k], 16'(16'h5300 + k)});
        else passCount++;
      end
    end
  endtask

  task automatic test_stream_stall;
    bit vIn [10];
    int opId [10];
    bit st [10];
    int expId [10];
    logic [33:0] expV;
    vIn   = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    opId  = '{1, 2, 3, 3, 3, 4, 0, 0, 0, 0};
    st    = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    expId = '{0, 0, 0, 0, 1, 2, 2, 3, 4, 0};
    for (int c = 0; c < 10; c++) begin
      inValid = vIn[c]; a = 16'(opId[c]); b = 16'd7; mode = 2'b00;
      instr = 16'(16'h5000 + opId[c]); stall = st[c];
      tick();
      expV = (expId[c] == 0) ? 34'd0 : {16'(expId[c] * 7), 2'b01, 16'(16'h5000 + expId[c])};
      checkCount++;
      if ({product, status, exInstr} !== expV)
        $display("[TB] FAIL stream[%0d]: got %h expected %h", c, {product, status, exInstr}, expV);
      else passCount++;
      if (c == 3) begin
        checkCount++;
        if (busy !== 1'b1)
          $display("[TB] FAIL stream_busy: got %b expected 1", busy);
        else passCount++;
      end
    end
    stall = 0;
  endtask

  task automatic test_flush;
    bit vIn [9];
    int opId [9];
    bit fl [9];
    int expId [9];
    logic [33:0] expV;
    vIn   = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    opId  = '{1, 2, 3, 4, 0, 0, 6, 0, 0};
    fl    = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    expId = '{0, 0, 1, 0, 0, 0, 0, 0, 6};
    for (int c = 0; c < 9; c++) begin
      inValid = vIn[c]; a = 16'(opId[c]); b = 16'd3; mode = 2'b00;
      instr = 16'(16'h5100 + opId[c]); flush = fl[c]; stall = fl[c];
      tick();
      expV = (expId[c] == 0) ? 34'd0 : {16'(expId[c] * 3), 2'b01, 16'(16'h5100 + expId[c])};
      checkCount++;
      if ({product, status, exInstr} !== expV)
        $display("[TB] FAIL flush[%0d]: got %h expected %h", c, {product, status, exInstr}, expV);
      else passCount++;
      if (c == 3) begin
        checkCount++;
        if (busy !== 1'b0)
          $display("[TB] FAIL flush_busy: got %b expected 0", busy);
        else passCount++;
      end
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_reset_midstream;
    for (int c = 0; c < 3; c++) begin
      inValid = 1; a = 16'(c + 1); b = 16'd9; mode = 2'b00; instr = 16'(16'h5401 + c);
      tick();
    end
    inValid = 0;
    checkCount++;
    if ({product, status, exInstr} !== {16'd9, 2'b01, 16'h5401})
      $display("[TB] FAIL midrst_pre: got %h expected %h", {product, status, exInstr}, {16'd9, 2'b01, 16'h5401});
    else passCount++;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({product, status, exInstr, busy} !== 35'd0)
      $display("[TB] FAIL midrst_async: got %h expected 0", {product, status, exInstr, busy});
    else passCount++;
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkCount++;
      if ({product, status, exInstr, busy} !== 35'd0)
        $display("[TB] FAIL midrst_after[%0d]: got %h expected 0", c, {product, status, exInstr, busy});
      else passCount++;
    end
  endtask

  task automatic test_param_w8;
    logic [7:0] opA [6];
    logic [7:0] opB [6];
    logic [1:0] opM [6];
    logic [7:0] expP [6];
    logic [1:0] expS [6];
    int k;
    opA  = '{8'd2,  8'd20,  8'd20,  8'hFD,  8'hFD,  8'hFD};
    opB  = '{8'd8,  8'd15,  8'd15,  8'd5,   8'd5,   8'd5};
    opM  = '{2'b00, 2'b00,  2'b10,  2'b01,  2'b11,  2'b00};
    expP = '{8'h10, 8'h2C,  8'h01,  8'hF1,  8'hFF,  8'hF1};
    expS = '{2'b01, 2'b11,  2'b01,  2'b01,  2'b01,  2'b11};
    for (int c = 0; c < 6 + S8 - 1; c++) begin
      if (c < 6) begin
        inValid8 = 1; a8 = opA[c]; b8 = opB[c]; mode8 = opM[c]; instr8 = 16'(16'h5800 + c);
      end else inValid8 = 0;
      tick();
      if (c >= S8 - 1) begin
        k = c - (S8 - 1);
        checkCount++;
        if ({product8, status8, exInstr8} !== {expP[k], expS[k], 16'(16'h5800 + k)})
          $display("[TB] FAIL w8[%0d]: got %h expected %h", k, {product8, status8, exInstr8},
                   {expP[k], expS[k], 16'(16'h5800 + k)});
        else passCount++;
      end
    end
    inValid8 = 0;
    tick();
    checkCount++;
    if ({product8, status8, busy8} !== 11'd0)
      $display("[TB] FAIL w8_bubble: got %h expected 0", {product8, status8, busy8});
    else passCount++;
  endtask

  task automatic test_param_w32;
    logic [31:0] opA [6];
    logic [31:0] opB [6];
    logic [1:0]  opM [6];
    logic [31:0] expP [6];
    logic [1:0]  expS [6];
    int k;
    opA  = '{32'd2, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    opB  = '{32'd8, 32'h0001_0003, 32'h0001_0003, 32'd5,         32'd5,         32'd5};
    opM  = '{2'b00, 2'b00,         2'b10,         2'b01,         2'b11,         2'b00};
    expP = '{32'h10, 32'h0003_0000, 32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    expS = '{2'b01, 2'b11,         2'b01,         2'b01,         2'b01,         2'b11};
    for (int c = 0; c < 6 + S32 - 1; c++) begin
      if (c < 6) begin
        inValid32 = 1; a32 = opA[c]; b32 = opB[c]; mode32 = opM[c]; instr32 = 16'(16'h5A00 + c);
      end else inValid32 = 0;
      tick();
      if (c == S32 - 2) begin
        checkCount++;
        if (status32 !== 2'b00)
          $display("[TB] FAIL w32_latency: status=%b expected 00", status32);
        else passCount++;
      end
      if (c >= S32 - 1) begin
        k = c - (S32 - 1);
        checkCount++;
        if ({product32, status32, exInstr32} !== {expP[k], expS[k], 16'(16'h5A00 + k)})
          $display("[TB] FAIL w32[%0d]: got %h expected %h", k, {product32, status32, exInstr32},
                   {expP[k], expS[k], 16'(16'h5A00 + k)});
        else passCount++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_low();
    test_overflow_high();
    test_signed();
    test_stream_stall();
    test_flush();
    test_reset_midstream();
    test_param_w8();
    test_param_w32();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
